// File: rtl/uart_pkg.sv
// Shared constants and width helpers for the UART TX/RX blocks and their FIFOs.
// Parameters only; no logic, so no latency or backpressure of its own.
package uart_pkg;

   localparam int UART_FIFO_WIDTH = 8;
   localparam int UART_FIFO_DEPTH = 16;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int fifo_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Read data follows raddr combinationally; writes land on the rising edge; no backpressure.
module uart_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int PW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are deliberately unreset; pointers alone define what is valid.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with level, threshold and sticky error flags.
// read_data valid the cycle after a push; push rejected when full unless popping in the same cycle.
module uart_fifo
   import uart_pkg::*;
#(
   parameter  int WIDTH    = UART_FIFO_WIDTH,
   parameter  int DEPTH    = UART_FIFO_DEPTH,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 1,
   localparam int CW       = fifo_cnt_w(DEPTH),
   localparam int PW       = fifo_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] write_data,
   input  logic             pop,
   output logic [WIDTH-1:0] read_data,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CW-1:0]    level,
   output logic             overflow,
   output logic             underflow
);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          push_ok, pop_ok, ram_we;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty        = (level_q == '0);
   assign full         = (level_q == CW'(DEPTH));
   assign almost_full  = (level_q >= CW'(AF_LEVEL));
   assign almost_empty = (level_q <= CW'(AE_LEVEL));
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A full FIFO can still take a push when the same cycle frees a slot.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      ram_we      = 1'b0;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            ram_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + CW'(1);
            2'b01:   level_d = level_q - CW'(1);
            default: level_d = level_q;
         endcase
         if (push && !push_ok) overflow_d  = 1'b1;
         if (pop && !pop_ok)   underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   uart_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (write_data),
      .raddr (rd_ptr_q),
      .rdata (read_data)
   );

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench: a DEPTH=5 instance for data/flag behaviour, a DEPTH=16 instance for thresholds.
// Expected words are queued at push time; a negedge monitor checks each accepted pop.
module tb_uart_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       flush5, push5, pop5;
   logic [7:0] wd5, rd5;
   logic       empty5, full5, ae5, af5, ovf5, udf5;
   logic [2:0] level5;

   logic       flush16, push16, pop16;
   logic [7:0] wd16, rd16;
   logic       empty16, full16, ae16, af16, ovf16, udf16;
   logic [4:0] level16;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   uart_fifo #(.WIDTH(8), .DEPTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .flush(flush5), .push(push5), .write_data(wd5),
      .pop(pop5), .read_data(rd5), .empty(empty5), .full(full5),
      .almost_empty(ae5), .almost_full(af5), .level(level5),
      .overflow(ovf5), .underflow(udf5)
   );

   uart_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1)) dut16 (
      .clk(clk), .rst_n(rst_n), .flush(flush16), .push(push16), .write_data(wd16),
      .pop(pop16), .read_data(rd16), .empty(empty16), .full(full16),
      .almost_empty(ae16), .almost_full(af16), .level(level16),
      .overflow(ovf16), .underflow(udf16)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs applied 1 time unit after a rising edge, held for exactly one edge.
   task automatic cyc5(input logic p, input logic [7:0] d, input logic o, input logic f);
      push5 = p; wd5 = d; pop5 = o; flush5 = f;
      @(posedge clk); #1;
      push5 = 1'b0; pop5 = 1'b0; flush5 = 1'b0;
   endtask

   task automatic push_exp5(input logic [7:0] d);
      exp_q.push_back(d);
      cyc5(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic cyc16(input logic p, input logic o);
      push16 = p; wd16 = 8'h00; pop16 = o; flush16 = 1'b0;
      @(posedge clk); #1;
      push16 = 1'b0; pop16 = 1'b0;
   endtask

   // Monitor: every pop the DUT will accept at the next edge must show the oldest queued word.
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && !flush5 && pop5 && !empty5) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_pop: got read_data %0h, expected no accepted pop", rd5);
            end else begin
               e = exp_q.pop_front();
               check("sb_data", rd5, e);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      push5 = 0; pop5 = 0; flush5 = 0; wd5 = 0;
      push16 = 0; pop16 = 0; flush16 = 0; wd16 = 0;
      #3;
      check("rst_empty", empty5, 1);
      check("rst_full", full5, 0);
      check("rst_ae", ae5, 1);
      check("rst_af", af5, 0);
      check("rst_level", level5, 0);
      check("rst_ovf", ovf5, 0);
      check("rst_udf", udf5, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill and drain
      for (int i = 1; i <= 5; i++) push_exp5(8'(i * 8'h11));
      check("fill_full", full5, 1);
      check("fill_level", level5, 5);
      check("fill_af", af5, 1);
      for (int i = 0; i < 5; i++) cyc5(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_empty", empty5, 1);
      check("drain_level", level5, 0);

      // Wrap: one push, ten push+pop, one pop
      push_exp5(8'hA0);
      for (int i = 1; i <= 10; i++) begin
         exp_q.push_back(8'(8'hA0 + i));
         cyc5(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
         check("wrap_level", level5, 1);
         check("wrap_empty", empty5, 0);
         check("wrap_full", full5, 0);
      end
      cyc5(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_end_empty", empty5, 1);
      check("wrap_udf", udf5, 0);

      // Overflow, drain, then flush with a push in the flush cycle
      for (int i = 1; i <= 5; i++) push_exp5(8'(8'h20 + i));
      check("pre_ovf", ovf5, 0);
      cyc5(1'b1, 8'h66, 1'b0, 1'b0);
      check("ovf_level", level5, 5);
      check("ovf_flag", ovf5, 1);
      for (int i = 0; i < 5; i++) cyc5(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_drained", empty5, 1);
      check("ovf_sticky", ovf5, 1);
      cyc5(1'b1, 8'h77, 1'b0, 1'b1);
      check("flush_ovf", ovf5, 0);
      check("flush_empty", empty5, 1);
      check("flush_level", level5, 0);

      // Simultaneous push+pop when empty, then when full
      exp_q.push_back(8'h3C);
      cyc5(1'b1, 8'h3C, 1'b1, 1'b0);
      check("pp_empty_level", level5, 1);
      check("pp_empty_udf", udf5, 1);
      check("pp_empty_rd", rd5, 8'h3C);
      for (int i = 1; i <= 4; i++) push_exp5(8'(8'h40 + i));
      check("pp_full_pre", full5, 1);
      exp_q.push_back(8'h99);
      cyc5(1'b1, 8'h99, 1'b1, 1'b0);
      check("pp_full_level", level5, 5);
      check("pp_full_rd", rd5, 8'h41);
      check("pp_full_ovf", ovf5, 0);
      for (int i = 0; i < 5; i++) cyc5(1'b0, 8'h00, 1'b1, 1'b0);
      check("pp_drain_empty", empty5, 1);
      check("udf_sticky", udf5, 1);
      cyc5(1'b0, 8'h00, 1'b0, 1'b1);
      check("flush_udf", udf5, 0);

      // Asynchronous reset in the middle of a cycle
      for (int i = 1; i <= 3; i++) push_exp5(8'(i));
      check("pre_rst_level", level5, 3);
      #3 rst_n = 1'b0;
      #1;
      check("arst_empty", empty5, 1);
      check("arst_level", level5, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_exp5(8'h5A);
      check("post_rst_empty", empty5, 0);
      check("post_rst_rd", rd5, 8'h5A);
      cyc5(1'b0, 8'h00, 1'b1, 1'b0);
      check("post_rst_drain", empty5, 1);

      // Thresholds on the DEPTH=16 instance
      for (int i = 1; i <= 16; i++) begin
         cyc16(1'b1, 1'b0);
         check("thr_up_level", level16, i);
         check("thr_up_af", af16, (i >= 14));
         check("thr_up_ae", ae16, (i <= 1));
         check("thr_up_full", full16, (i == 16));
      end
      for (int i = 15; i >= 0; i--) begin
         cyc16(1'b0, 1'b1);
         check("thr_dn_af", af16, (i >= 14));
         check("thr_dn_ae", ae16, (i <= 1));
      end
      check("thr_empty", empty16, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2, need not be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, fill level at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1, fill level at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents and flags.
REQ-008 SHALL have port push  input  1  write request.
REQ-009 SHALL have port write_data  input  WIDTH  word to write.
REQ-010 SHALL have port pop  input  1  read acknowledge.
REQ-011 SHALL have port read_data  output  WIDTH  oldest stored word.
REQ-012 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-013 SHALL have port level  output  CW  current entry count, CW = $clog2(DEPTH+1).
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL present read_data first-word-fall-through: read_data = entry at rd_ptr, combinational from registered state, valid whenever empty=0.
REQ-016 SHALL accept push when full=0 or (full=1 and pop=1): write_data stored at wr_ptr, wr_ptr advances.
REQ-017 SHALL accept pop when empty=0: rd_ptr advances; pop while empty is ignored.
REQ-018 SHALL ignore push when full=1 and pop=0, leaving contents and level unchanged.
REQ-019 SHALL wrap each pointer from DEPTH-1 to 0; pointer width $clog2(DEPTH); no power-of-two masking.
REQ-020 SHALL update level +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither; level never exceeds DEPTH nor goes below 0.
REQ-021 SHALL, on simultaneous push and pop while empty, accept the push only (level becomes 1, underflow set).
REQ-022 SHALL, on simultaneous push and pop while full, accept both (level stays DEPTH, oldest word replaced in order).
REQ-023 SHALL derive empty = (level==0), full = (level==DEPTH), almost_full = (level>=AF_LEVEL), almost_empty = (level<=AE_LEVEL), all from registered level, zero added latency.
REQ-024 SHALL set overflow on a rejected push and underflow on an ignored pop, one cycle after the event; both hold until flush or reset.
REQ-025 SHALL give flush priority over push and pop: next cycle pointers=0, level=0, overflow=underflow=0; push/pop in the flush cycle discarded.
REQ-026 SHALL not clear storage contents on flush or reset; only pointers and level.

Reset
REQ-027 SHALL, while rst_n=0, immediately force wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0, hence empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>=1).
REQ-028 SHALL treat reset mid-operation as discarding all stored words; first accepted push after release appears on read_data the next cycle.
REQ-029 SHALL release on rising rst_n with no pending state; storage array SHALL be unreset.

Structure
REQ-030 SHALL place shared width helpers (CW, pointer width) and default WIDTH/DEPTH constants in the common uart_pkg/defines header shared with the UART TX/RX blocks.
REQ-031 SHALL instantiate one sub-module, uart_fifo_ram (DEPTH x WIDTH, one write port, one asynchronous read port); pointer/level/flag control stays in uart_fifo.

Verification
REQ-032 SHALL test fill/drain with DEPTH=5: push 0x11..0x55 -> full=1, level=5; pop x5 -> read_data 0x11..0x55 in order, empty=1.
REQ-033 SHALL test wrap with DEPTH=5: 12 interleaved push/pop cycles -> pointers wrap 4->0, data order preserved, no flag glitches.
REQ-034 SHALL test overflow: push 0x66 while full, no pop -> level stays 5, overflow=1 next cycle, 0x66 never read; flush -> overflow=0, empty=1.
REQ-035 SHALL test simultaneous push+pop: when empty -> level=1, underflow=1, read_data=written value; when full -> level=5, oldest word popped.
REQ-036 SHALL test thresholds DEPTH=16, AF_LEVEL=14, AE_LEVEL=1: almost_full asserts at level 14, almost_empty deasserts at level 2.
REQ-037 SHALL test async reset asserted mid-clock with level=3 -> empty=1, level=0 before next clk edge; new push after release readable next cycle.
